// File: rtl/ap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ap_pkg
// Description : Shared types and constants for the STE automata engine.
// Revision    : 1.0 - initial release
// ============================================================================
package ap_pkg;

    // Start behaviour of a state-transition element
    typedef enum logic [1:0] {
        MODE_NONE          = 2'd0,
        MODE_START_OF_DATA = 2'd1,
        MODE_ALL_INPUT     = 2'd2
    } start_mode_e;

    // cfg_field encodings
    localparam logic [1:0] CFG_VALUE = 2'd0;
    localparam logic [1:0] CFG_MASK  = 2'd1;
    localparam logic [1:0] CFG_MODE  = 2'd2;
    localparam logic [1:0] CFG_ADJ   = 2'd3;

    // Engine stream state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Report entry layout at the default engine widths
    localparam int RPT_OFFSET_W = 32;
    localparam int RPT_VECTOR_W = 8;

    typedef struct packed {
        logic [RPT_OFFSET_W-1:0] offset;
        logic [RPT_VECTOR_W-1:0] vector;
    } rpt_entry_t;

    // Raw mode code 3 is unassigned and behaves as NONE
    function automatic start_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    decode_mode = MODE_START_OF_DATA;
            2'd2:    decode_mode = MODE_ALL_INPUT;
            default: decode_mode = MODE_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ap_report_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ap_report_fifo
// Description : Synchronous FIFO with full/empty flags and same-cycle
//               push/pop. Head data reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_report_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_q, wr_d;
    logic [PTR_W:0]   rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                     (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);

    // A pop frees the slot at full, so a simultaneous push still lands
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign data_o  = empty_o ? '0 : mem_q[rd_q[PTR_W-1:0]];

    // Pointer next-state
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop)  rd_d = rd_q + PTR_ONE;
    end

    // Pointer registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q[PTR_W-1:0]] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/ap_ste_engine.sv
`default_nettype none
// ============================================================================
// Module      : ap_ste_engine
// Description : Runtime-programmable automata engine of NUM_STE state
//               transition elements with a queued report output.
// Revision    : 1.0 - initial release
// ============================================================================
module ap_ste_engine
    import ap_pkg::*;
#(
    parameter int  CHAR_W    = 16,
    parameter int  NUM_STE   = 8,
    parameter int  OFFSET_W  = 32,
    parameter int  RPT_DEPTH = 16,
    localparam int STE_IDX_W = (NUM_STE > 1) ? $clog2(NUM_STE) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    output logic                 cfg_ready,
    input  logic [STE_IDX_W-1:0] cfg_ste,
    input  logic [1:0]           cfg_field,
    input  logic [CHAR_W-1:0]    cfg_data,
    input  logic                 char_valid,
    output logic                 char_ready,
    input  logic [CHAR_W-1:0]    character,
    input  logic                 char_last,
    output logic                 rpt_valid,
    input  logic                 rpt_ready,
    output logic [OFFSET_W-1:0]  rpt_offset,
    output logic [NUM_STE-1:0]   rpt_vector,
    output logic                 busy
);

    localparam logic [OFFSET_W-1:0] OFFSET_ONE = {{(OFFSET_W-1){1'b0}}, 1'b1};

    // Per-STE configuration
    logic [CHAR_W-1:0]  value_q [NUM_STE];
    logic [CHAR_W-1:0]  mask_q  [NUM_STE];
    start_mode_e        mode_q  [NUM_STE];
    logic [NUM_STE-1:0] adj_q   [NUM_STE];
    logic [NUM_STE-1:0] rpt_en_q;

    // Stream state
    state_e              state_q, state_d;
    logic [NUM_STE-1:0]  active_q, active_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;

    logic [NUM_STE-1:0]  enabled;
    logic [NUM_STE-1:0]  match;
    logic [NUM_STE-1:0]  active_nx;
    logic [NUM_STE-1:0]  rep;
    logic                accept;
    logic                push;
    logic                fifo_full;
    logic                fifo_empty;

    assign char_ready = reset_n && !fifo_full;
    assign accept     = char_valid && char_ready;

    // Configuration registers; writes land only while the engine is idle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STE; i++) begin
                value_q[i] <= '0;
                mask_q[i]  <= '0;
                mode_q[i]  <= MODE_NONE;
                adj_q[i]   <= '0;
            end
            rpt_en_q <= '0;
        end else if (cfg_we && cfg_ready) begin
            case (cfg_field)
                CFG_VALUE: value_q[cfg_ste] <= cfg_data;
                CFG_MASK:  mask_q[cfg_ste]  <= cfg_data;
                CFG_MODE: begin
                    mode_q[cfg_ste]   <= decode_mode(cfg_data[1:0]);
                    rpt_en_q[cfg_ste] <= cfg_data[2];
                end
                default:   adj_q[cfg_ste]   <= cfg_data[NUM_STE-1:0];
            endcase
        end
    end

    // Enable and match are purely combinational on the presented character
    for (genvar i = 0; i < NUM_STE; i++) begin : g_ste
        assign enabled[i] = active_q[i] ||
                            (mode_q[i] == MODE_ALL_INPUT) ||
                            ((mode_q[i] == MODE_START_OF_DATA) && (state_q == ST_IDLE));
        assign match[i]   = enabled[i] &&
                            ((character & mask_q[i]) == (value_q[i] & mask_q[i]));
    end

    // Each matching STE forwards activation along its adjacency row
    always_comb begin
        active_nx = '0;
        for (int j = 0; j < NUM_STE; j++) begin
            if (match[j]) active_nx = active_nx | adj_q[j];
        end
    end

    assign rep  = match & rpt_en_q;
    assign push = accept && (rep != '0);

    // Active vector and offset advance per accepted beat; the last beat resets them
    always_comb begin
        active_d = active_q;
        offset_d = offset_q;
        if (accept) begin
            if (char_last) begin
                active_d = '0;
                offset_d = '0;
            end else begin
                active_d = active_nx;
                offset_d = offset_q + OFFSET_ONE;
            end
        end
    end

    // Stream state registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            active_q <= '0;
            offset_q <= '0;
        end else begin
            active_q <= active_d;
            offset_q <= offset_d;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state and status outputs
    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        cfg_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (accept && !char_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (accept && char_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ap_report_fifo #(
        .WIDTH (OFFSET_W + NUM_STE),
        .DEPTH (RPT_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push),
        .data_i  ({offset_q, rep}),
        .pop_i   (rpt_ready),
        .data_o  ({rpt_offset, rpt_vector}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rpt_valid = !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_ap_ste_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ap_ste_engine
// Description : Scoreboard bench for ap_ste_engine with directed streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ap_ste_engine;
    import ap_pkg::*;

    localparam int CHAR_W    = 16;
    localparam int NUM_STE   = 8;
    localparam int OFFSET_W  = 32;
    localparam int RPT_DEPTH = 4;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                cfg_we;
    logic                cfg_ready;
    logic [2:0]          cfg_ste;
    logic [1:0]          cfg_field;
    logic [CHAR_W-1:0]   cfg_data;
    logic                char_valid;
    logic                char_ready;
    logic [CHAR_W-1:0]   character;
    logic                char_last;
    logic                rpt_valid;
    logic                rpt_ready;
    logic [OFFSET_W-1:0] rpt_offset;
    logic [NUM_STE-1:0]  rpt_vector;
    logic                busy;

    ap_ste_engine #(
        .CHAR_W    (CHAR_W),
        .NUM_STE   (NUM_STE),
        .OFFSET_W  (OFFSET_W),
        .RPT_DEPTH (RPT_DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we),
        .cfg_ready  (cfg_ready),
        .cfg_ste    (cfg_ste),
        .cfg_field  (cfg_field),
        .cfg_data   (cfg_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .character  (character),
        .char_last  (char_last),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_offset (rpt_offset),
        .rpt_vector (rpt_vector),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    rpt_entry_t exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks hold stability
    logic                hold_q = 1'b0;
    logic [OFFSET_W-1:0] held_off;
    logic [NUM_STE-1:0]  held_vec;
    rpt_entry_t          mon_e;

    always @(negedge clock) begin
        if (!reset_n) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_offset", 64'(rpt_offset), 64'(held_off));
                check("hold_vector", 64'(rpt_vector), 64'(held_vec));
            end
            if (rpt_valid && rpt_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_report: got off=%0d vec=%b, expected no entry",
                             rpt_offset, rpt_vector);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rpt_offset", 64'(rpt_offset), 64'(mon_e.offset));
                    check("rpt_vector", 64'(rpt_vector), 64'(mon_e.vector));
                end
            end
            hold_q   = rpt_valid && !rpt_ready;
            held_off = rpt_offset;
            held_vec = rpt_vector;
        end
    end

    // All tasks start and end at 1 time unit after a rising edge
    task automatic cfg_write(input logic [2:0] ste, input logic [1:0] f, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_ste   = ste;
        cfg_field = f;
        cfg_data  = d;
        @(posedge clock); #1;
        cfg_we    = 1'b0;
    endtask

    task automatic send_char(input logic [15:0] c, input logic last,
                             input logic exp_v, input logic [31:0] eo, input logic [7:0] ev);
        int n;
        rpt_entry_t e;
        char_valid = 1'b1;
        character  = c;
        char_last  = last;
        n = 0;
        @(negedge clock);
        while (!char_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!char_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: char 0x%0h not accepted, expected acceptance", c);
        end else if (exp_v) begin
            e.offset = eo;
            e.vector = ev;
            exp_q.push_back(e);
        end
        @(posedge clock); #1;
        char_valid = 1'b0;
        char_last  = 1'b0;
        character  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        idle(2);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        cfg_we     = 1'b0;
        cfg_ste    = '0;
        cfg_field  = '0;
        cfg_data   = '0;
        char_valid = 1'b0;
        character  = '0;
        char_last  = 1'b0;
        rpt_ready  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_char_ready", 64'(char_ready), 64'd0);
        check("rst_rpt_valid",  64'(rpt_valid),  64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_cfg_ready",  64'(cfg_ready),  64'd1);
        check("rst_rpt_offset", 64'(rpt_offset), 64'd0);
        check("rst_rpt_vector", 64'(rpt_vector), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(1);

        // Common configuration
        cfg_write(3'd0, CFG_MODE,  16'h0002);
        cfg_write(3'd0, CFG_VALUE, 16'h4100);
        cfg_write(3'd0, CFG_MASK,  16'hFF00);
        cfg_write(3'd1, CFG_VALUE, 16'h4343);
        cfg_write(3'd1, CFG_MASK,  16'hFFFF);
        cfg_write(3'd1, CFG_MODE,  16'h0004);
        cfg_write(3'd2, CFG_VALUE, 16'h4300);
        cfg_write(3'd2, CFG_MASK,  16'hFF00);
        cfg_write(3'd2, CFG_MODE,  16'h0004);
        cfg_write(3'd0, CFG_ADJ,   16'h0002);
        cfg_write(3'd1, CFG_ADJ,   16'h0006);

        // Chained match stream
        send_char(16'h4141, 1'b0, 1'b0, 32'd0, 8'b000);
        check("s1_busy_run", 64'(busy), 64'd1);
        send_char(16'h4343, 1'b0, 1'b1, 32'd1, 8'b010);
        send_char(16'h4343, 1'b0, 1'b1, 32'd2, 8'b110);
        send_char(16'h4354, 1'b1, 1'b1, 32'd3, 8'b100);
        check("s1_busy_done", 64'(busy), 64'd0);
        wait_drain("s1_drain");

        // Lone STE1 character: not active, so nothing reported
        send_char(16'h4343, 1'b1, 1'b0, 32'd0, 8'b000);
        check("s2_busy", 64'(busy), 64'd0);
        idle(4);

        // START_OF_DATA on STE0; offset 0 also shows the previous clears
        cfg_write(3'd0, CFG_VALUE, 16'h4141);
        cfg_write(3'd0, CFG_MASK,  16'hFFFF);
        cfg_write(3'd0, CFG_MODE,  16'h0005);
        send_char(16'h4141, 1'b0, 1'b1, 32'd0, 8'b001);
        send_char(16'h4141, 1'b1, 1'b0, 32'd0, 8'b000);
        send_char(16'h4141, 1'b1, 1'b1, 32'd0, 8'b001);
        wait_drain("s3_drain");

        // Backpressure: STE0 matches everything and reports every beat
        cfg_write(3'd0, CFG_VALUE, 16'h0000);
        cfg_write(3'd0, CFG_MASK,  16'h0000);
        cfg_write(3'd0, CFG_MODE,  16'h0006);
        rpt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_char(16'h0010 + 16'(i), 1'b0, 1'b1, 32'(i), 8'b001);
        end
        @(negedge clock);
        check("s4_full_char_ready", 64'(char_ready), 64'd0);
        check("s4_full_rpt_valid",  64'(rpt_valid),  64'd1);
        check("s4_full_head_off",   64'(rpt_offset), 64'd0);
        @(posedge clock); #1;
        rpt_ready = 1'b1;
        send_char(16'h0020, 1'b1, 1'b1, 32'd4, 8'b001);
        wait_drain("s4_drain");

        // Config write during RUN must be ignored
        send_char(16'h0000, 1'b0, 1'b1, 32'd0, 8'b001);
        check("s5_busy",      64'(busy),      64'd1);
        check("s5_cfg_ready", 64'(cfg_ready), 64'd0);
        cfg_write(3'd0, CFG_MODE, 16'h0000);
        send_char(16'h0000, 1'b0, 1'b1, 32'd1, 8'b001);
        wait_drain("s5_drain");

        // Reset mid-stream with a queued report
        rpt_ready = 1'b0;
        send_char(16'h0000, 1'b0, 1'b1, 32'd2, 8'b001);
        @(negedge clock);
        check("s5_queued", 64'(rpt_valid), 64'd1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clock);
        @(posedge clock); #1;
        @(negedge clock);
        check("s5_rst_rpt_valid",  64'(rpt_valid),  64'd0);
        check("s5_rst_busy",       64'(busy),       64'd0);
        check("s5_rst_char_ready", 64'(char_ready), 64'd0);
        check("s5_rst_rpt_offset", 64'(rpt_offset), 64'd0);
        @(posedge clock); #1;
        reset_n   = 1'b1;
        rpt_ready = 1'b1;
        idle(1);
        check("s5_cfg_ready_after", 64'(cfg_ready), 64'd1);
        send_char(16'h4141, 1'b0, 1'b0, 32'd0, 8'b000);
        send_char(16'h4343, 1'b0, 1'b0, 32'd0, 8'b000);
        send_char(16'h0000, 1'b1, 1'b0, 32'd0, 8'b000);
        idle(4);
        check("s5_no_reports", 64'(rpt_valid), 64'd0);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ap_ste_engine.md
Name: ap_ste_engine

Overview:
- Parametrised automata-processing engine: NUM_STE programmable state-transition elements evaluated against one CHAR_W-bit character per accepted beat.
- Match criteria, start modes, report enables and the adjacency matrix are loaded at runtime through a config port. Nothing is hard-wired per STE.
- Matches on report-enabled STEs push {offset, report vector} entries into an internal report FIFO with ready/valid output.
- Sits between the character stream source and the report collector.

Parameters:
- CHAR_W, 16, character width in bits.
- NUM_STE, 8, number of STEs; must be ≤ CHAR_W.
- OFFSET_W, 32, stream offset counter width.
- RPT_DEPTH, 16, report FIFO depth; must be a power of 2, ≥ 2.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_ready  out  1  config writes accepted; high only in IDLE.
- cfg_ste  in  clog2(NUM_STE)  target STE index.
- cfg_field  in  2  0=value, 1=mask, 2=mode, 3=adjacency row.
- cfg_data  in  CHAR_W  write data, LSB-aligned.
- char_valid  in  1  character beat valid.
- char_ready  out  1  engine can accept a beat.
- character  in  CHAR_W  input character.
- char_last  in  1  final character of the stream.
- rpt_valid  out  1  report entry available.
- rpt_ready  in  1  collector pops the entry.
- rpt_offset  out  OFFSET_W  stream offset of the reporting character.
- rpt_vector  out  NUM_STE  bit i set means STE i reported.
- busy  out  1  state is RUN.

Behaviour:
- Reset (reset_n=0 at a clock edge) sets the following:
  - All value, mask and adjacency registers to 0; start mode to NONE; report_en to 0.
  - Active vector and offset counter to 0.
  - FIFO emptied: rpt_valid=0, rpt_offset=0, rpt_vector=0.
  - State to IDLE; char_ready=0 during the reset cycle.
- Reset mid-stream discards all in-flight state and queued reports.
- Config writes:
  - Applied at the edge when cfg_we && cfg_ready.
  - Writes in RUN are ignored.
  - Mode field: cfg_data[1:0] is start mode (0=NONE, 1=START_OF_DATA, 2=ALL_INPUT, 3 treated as NONE); cfg_data[2] is report_en.
  - Adjacency row for STE j: cfg_data[NUM_STE-1:0]; bit i set means STE j enables STE i.
- Accept condition: char_valid && char_ready, where char_ready = reset_n && !fifo_full.
- An STE is enabled for an accepted character if any of these holds:
  - active[i] is set;
  - its mode is ALL_INPUT;
  - its mode is START_OF_DATA and state is IDLE.
- STE i matches when it is enabled and (character & mask_i) == (value_i & mask_i). Match logic is combinational on the accepted character.
- Next active vector:
  - active_next[i] = OR over j of (match[j] & adj[j][i]).
  - Registered on accept; held when no beat is accepted.
- Reporting:
  - rep = match & report_en. If rep ≠ 0, push {offset, rep} into the FIFO.
  - The entry is visible on rpt_valid the cycle after acceptance.
  - No drop is possible: each beat pushes at most one entry, and accept requires !full.
- Offset counter: offset of the current character, starting at 0 and incremented on each accept. Wraps modulo 2^OFFSET_W.
- State machine: IDLE→RUN on accept with char_last=0. RUN→IDLE on accept with char_last=1.
- Accepting char_last in either state:
  - clears the active vector and offset;
  - still evaluates and reports that character normally.
- A single-beat stream (char_last in IDLE) stays in IDLE.
- Config write and character accept in the same IDLE cycle: the character is evaluated with the old config; the new config is applied at that edge.
- FIFO:
  - Push and pop in the same cycle are both honoured, including at the empty and full boundaries.
  - Pointers wrap at RPT_DEPTH.
  - Outputs hold stable while rpt_valid && !rpt_ready.

Decomposition:
- Package ap_pkg holds the following:
  - start-mode enum (NONE, START_OF_DATA, ALL_INPUT);
  - cfg_field constants;
  - state enum (IDLE, RUN);
  - report entry typedef.
- One sub-module, ap_report_fifo: a synchronous FIFO parametrised by width and depth, with full/empty flags and same-cycle push/pop.

Test Plan:
- Common config for the first two scenarios:
  - STE0: ALL_INPUT, value 0x4100, mask 0xFF00.
  - STE1: value 0x4343, mask 0xFFFF, report.
  - STE2: value 0x4300, mask 0xFF00, report.
  - Adjacency: 0→1, 1→{1,2}.
- Common-config stream 0x4141, 0x4343, 0x4343, 0x4354(last) → reports {1,0b010}, {2,0b110}, {3,0b100}; busy=0 after the last beat.
- Common config, stream 0x4343 alone (last) → no report, since STE1 is not active; active and offset cleared.
- START_OF_DATA STE0 (value 0x4141, mask 0xFFFF, report) → stream 0x4141, 0x4141 gives one report {0,0b001}. A second stream 0x4141(last) gives {0,0b001} again.
- Hold rpt_ready=0 with RPT_DEPTH=4 and a report on every beat → char_ready falls after 4 entries. Raising rpt_ready drains entries in order with offsets 0..3 and no loss.
- Issue cfg_we while busy=1 → write ignored and matching unchanged. Assert reset_n=0 mid-stream → rpt_valid=0, busy=0, and all config reads back as no-match/no-report.
